// File: rtl/screen_wipe_pkg.sv
// Shared types and constants for the screen_wipe rectangle fill engine.
// Visible screen limits, coordinate widths and the 2-bit state encoding.
package screen_wipe_pkg;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;
    localparam int COORD_W      = 10;
    localparam int SUM_W        = COORD_W + 1;
    localparam int COL_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One extra bit so that a corner near 1023 plus an offset cannot wrap back on-screen.
    function automatic logic [SUM_W-1:0] coord_sum(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/screen_wipe_raster.sv
// wipe_raster: cx/cy raster counters for screen_wipe, x fastest.
// last_o flags the final pixel of the w x h rectangle.
module wipe_raster
    import screen_wipe_pkg::*;
(
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    output logic [COORD_W-1:0] cx_o,
    output logic [COORD_W-1:0] cy_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               x_end;

    always_comb begin
        x_end  = (cx_q == w_i - ONE);
        last_o = x_end && (cy_q == h_i - ONE);
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (clr_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step_i) begin
            if (x_end) begin
                cx_d = '0;
                cy_d = cy_q + ONE;
            end else begin
                cx_d = cx_q + ONE;
            end
        end
    end

    // No reset needed: LOAD always clears the counters before a sweep uses them.
    always_ff @(posedge clk_i) begin
        cx_q <= cx_d;
        cy_q <= cy_d;
    end

    assign cx_o = cx_q;
    assign cy_o = cy_q;

endmodule

// File: rtl/screen_wipe.sv
// screen_wipe: sweeps a rectangle one pixel per clock and emits registered plot strobes.
// Define SCREEN_WIPE_BORDER_EN to paint the rectangle outline in the inverted colour.
//
// state    | meaning
// IDLE     | waiting for go
// LOAD     | latch rectangle and colour, clear raster counters
// SWEEP    | one pixel per cycle, then one flush cycle after the last pixel
// DONE     | done pulse, busy still high
module screen_wipe
    import screen_wipe_pkg::*;
#(
    parameter int X_MAX = SCREEN_X_MAX,
    parameter int Y_MAX = SCREEN_Y_MAX
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               go_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    input  logic [COL_W-1:0]   fill_colour_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               writeEn_o,
    output logic [COORD_W-1:0] x_out_o,
    output logic [COORD_W-1:0] y_out_o,
    output logic [COL_W-1:0]   colour_o
);

    localparam logic [SUM_W-1:0] X_LIM = SUM_W'(X_MAX);
    localparam logic [SUM_W-1:0] Y_LIM = SUM_W'(Y_MAX);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x0_q, y0_q, w_q, h_q;
    logic [COL_W-1:0]   fill_q;
    logic               flush_q, flush_d;
    logic               we_q, we_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COL_W-1:0]   col_q, col_d;

    logic [COORD_W-1:0] cx, cy;
    logic               last, clr, step, pix_active, visible;
    logic [SUM_W-1:0]   sum_x, sum_y;
    logic [COL_W-1:0]   pix_colour;

    wipe_raster u_raster (
        .clk_i  (CLOCK_50),
        .clr_i  (clr),
        .step_i (step),
        .w_i    (w_q),
        .h_i    (h_q),
        .cx_o   (cx),
        .cy_o   (cy),
        .last_o (last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go_i) state_d = ST_LOAD;
            ST_LOAD:  state_d = (w_i == '0 || h_i == '0) ? ST_DONE : ST_SWEEP;
            ST_SWEEP: if (flush_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr        = (state_q == ST_LOAD);
        pix_active = (state_q == ST_SWEEP) && !flush_q;
        step       = pix_active;
        flush_d    = pix_active && last;
        sum_x      = coord_sum(x0_q, cx);
        sum_y      = coord_sum(y0_q, cy);
        visible    = (sum_x <= X_LIM) && (sum_y <= Y_LIM);
`ifdef SCREEN_WIPE_BORDER_EN
        pix_colour = (cx == '0 || cx == w_q - COORD_W'(1) || cy == '0 || cy == h_q - COORD_W'(1))
                   ? ~fill_q : fill_q;
`else
        pix_colour = fill_q;
`endif
        we_d   = pix_active && visible;
        // Coordinates and colour only move on a plotted pixel so draw_mux sees stable values.
        x_d    = we_d ? sum_x[COORD_W-1:0] : x_q;
        y_d    = we_d ? sum_y[COORD_W-1:0] : y_q;
        col_d  = we_d ? pix_colour : col_q;
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            fill_q  <= '0;
            flush_q <= 1'b0;
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            if (state_q == ST_LOAD) begin
                x0_q   <= x0_i;
                y0_q   <= y0_i;
                w_q    <= w_i;
                h_q    <= h_i;
                fill_q <= fill_colour_i;
            end
            flush_q <= flush_d;
            we_q    <= we_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

    assign writeEn_o = we_q;
    assign x_out_o   = x_q;
    assign y_out_o   = y_q;
    assign colour_o  = col_q;

endmodule
